cal_engine: RTL and testbench
=============================

CAL_ENGINE -- requirements
Module: cal_engine

Interface
REQ-001 SHALL provide parameter W, default 16, sample and coefficient width in bits.
REQ-002 SHALL provide parameter N, default 4, channel count (N >= 2).
REQ-003 SHALL provide parameter SHIFT, default 8, gain fraction bits (unity gain = 1<<SHIFT).
REQ-004 SHALL provide parameter CLAMP_HI, default 26000, upper output clamp (signed).
REQ-005 SHALL provide parameter CLAMP_LO, default -26000, lower output clamp (signed).
REQ-006 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-007 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-008 SHALL have port sample_valid  in  1  one-cycle strobe requesting calibration of uncal_in.
REQ-009 SHALL have port uncal_in  in  N*W  packed signed inputs, channel c at bits [c*W +: W].
REQ-010 SHALL have port cal_out  out  N*W  packed signed calibrated outputs, same packing.
REQ-011 SHALL have port cal_valid  out  1  one-cycle pulse: all cal_out lanes updated.
REQ-012 SHALL have port busy  out  1  high while a sample set is in flight.
REQ-013 SHALL have port coef_we  in  1  coefficient write strobe.
REQ-014 SHALL have port coef_addr  in  $clog2(N)+1  bit0: 0=offset, 1=gain; upper bits: channel.
REQ-015 SHALL have port coef_wdata  in  W  signed coefficient value.
REQ-016 SHALL have port clip_flags  out  N  sticky per-channel clamp indicators.
REQ-017 SHALL have port clip_clr  in  1  clears clip_flags and overrun.
REQ-018 SHALL have port overrun  out  1  sticky: sample_valid arrived while busy.

Function
REQ-019 SHALL implement states IDLE and CALC; IDLE on reset.
REQ-020 IDLE with sample_valid high at edge k SHALL latch all N uncal_in lanes, set busy, enter CALC.
REQ-021 CALC SHALL issue one channel per cycle, channel 0 first, through a 2-stage pipeline: stage 1 registers (in - offset) * gain, stage 2 shifts, clamps and writes the lane.
REQ-022 Channel c SHALL be written at edge k+c+2; the last lane and cal_valid=1 SHALL register at edge k+N+1; busy SHALL clear and state return to IDLE at the same edge.
REQ-023 cal_valid SHALL be high exactly one cycle per accepted sample set; lanes SHALL hold their values between updates.
REQ-024 Arithmetic: difference SHALL be W+1 bits signed; product SHALL keep full 2W+2 bits signed; result SHALL be product >>> SHIFT (arithmetic, truncation toward -inf).
REQ-025 Clamp SHALL compare the full-width result: > CLAMP_HI -> CLAMP_HI; < CLAMP_LO -> CLAMP_LO; else low W bits. Any clamp sets clip_flags[c].
REQ-026 sample_valid while busy SHALL be ignored (no re-latch) and SHALL set overrun.
REQ-027 clip_clr SHALL clear clip_flags and overrun; a set in the same cycle SHALL win.
REQ-028 coef_we SHALL write offset/gain of the addressed channel at the edge; writes to channel >= N SHALL be ignored.
REQ-029 A channel issued in the same cycle as a write to its coefficient SHALL use the old value; later issues use the new value; writes are accepted in any state.

Reset
REQ-030 rst SHALL force: state IDLE, busy 0, cal_valid 0, all cal_out lanes 0, clip_flags 0, overrun 0, all offsets 0, all gains 1<<SHIFT.
REQ-031 rst during CALC SHALL abort the set with no cal_valid pulse; takes priority over sample_valid and coef_we.

Verification (W=16, N=4, SHIFT=8)
REQ-032 After reset, uncal_in={100,-200,300,-400}, sample_valid at edge k -> cal_out equals inputs, cal_valid only in cycle after edge k+5, busy high edges k..k+4.
REQ-033 Write offset ch1=50, gain ch1=512; in1=150 -> lane1=200; other lanes unchanged from inputs.
REQ-034 Gain ch0=0x7FFF, in0=10000 -> lane0=26000, clip_flags=0001; in0=-10000 -> -26000; clip_clr -> clip_flags=0000.
REQ-035 sample_valid at k and k+2 -> only first set output, one cal_valid, overrun=1; next strobe at k+6 accepted normally.
REQ-036 rst asserted at edge k+3 of a set -> no cal_valid, cal_out all 0, busy 0, gains read back as unity (in=1234 -> out=1234).

Source files
------------

// File: rtl/cal_engine.sv
// cal_engine: per-channel offset/gain calibration of an N-lane sample set.
// A strobe on sample_valid latches all lanes. The lanes then pass one per
// cycle through a two-stage pipeline:
//   stage 1 registers (in - offset) * gain
//   stage 2 applies >>> SHIFT, clamps the result and writes the lane.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   sample_valid, uncal_in   sample-set request and packed signed inputs
//   cal_out, cal_valid       packed calibrated outputs and one-cycle done pulse
//   busy                     a sample set is in flight
//   coef_we/addr/wdata       coefficient writes; addr bit0 selects offset(0)
//                            or gain(1), and the upper bits select the channel
//   clip_flags, overrun      sticky status bits, cleared by clip_clr
module cal_engine #(
  parameter int W        = 16,
  parameter int N        = 4,
  parameter int SHIFT    = 8,
  parameter int CLAMP_HI = 26000,
  parameter int CLAMP_LO = -26000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_valid,
  input  logic [N*W-1:0]       uncal_in,
  output logic [N*W-1:0]       cal_out,
  output logic                 cal_valid,
  output logic                 busy,
  input  logic                 coef_we,
  input  logic [$clog2(N):0]   coef_addr,
  input  logic [W-1:0]         coef_wdata,
  output logic [N-1:0]         clip_flags,
  input  logic                 clip_clr,
  output logic                 overrun
);
  localparam int CW = $clog2(N);
  localparam int PW = 2*W + 2;
  localparam logic signed [PW-1:0] HI = PW'(CLAMP_HI);
  localparam logic signed [PW-1:0] LO = PW'(CLAMP_LO);

  typedef enum logic {IDLE, CALC} state_t;
  state_t state, state_nxt;

  logic signed [W-1:0]  lat    [N];
  logic signed [W-1:0]  offset [N];
  logic signed [W-1:0]  gain   [N];
  logic [CW:0]          idx;
  logic [CW-1:0]        idx_ch;
  logic                 issue, accept, last_wr;
  logic                 s1_vld;
  logic [CW-1:0]        s1_ch;
  logic signed [PW-1:0] s1_prod;
  logic signed [W:0]    diff;
  logic signed [PW-1:0] prod, res;
  logic                 clip_hi, clip_lo;
  logic signed [W-1:0]  lane_val;
  logic [N-1:0]         clip_set;
  logic [CW-1:0]        wr_ch;
  logic                 wr_ok;

  assign busy   = (state == CALC);
  assign idx_ch = idx[CW-1:0];
  assign wr_ch  = coef_addr[CW:1];
  assign wr_ok  = ({1'b0, wr_ch} < (CW+1)'(N));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    accept    = 1'b0;
    last_wr   = s1_vld && (s1_ch == CW'(N-1));
    case (state)
      IDLE: begin
        if (sample_valid) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        issue = (idx < (CW+1)'(N));
        if (last_wr) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Coefficients are read combinationally here, so a write landing on the
  // same edge as an issue is not yet visible to that channel.
  always_comb begin
    diff     = (W+1)'(lat[idx_ch]) - (W+1)'(offset[idx_ch]);
    prod     = PW'(diff) * PW'(gain[idx_ch]);
    res      = s1_prod >>> SHIFT;
    clip_hi  = (res > HI);
    clip_lo  = (res < LO);
    lane_val = clip_hi ? W'(CLAMP_HI) : (clip_lo ? W'(CLAMP_LO) : res[W-1:0]);
    clip_set = '0;
    if (s1_vld && (clip_hi || clip_lo)) clip_set[s1_ch] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      s1_vld     <= 1'b0;
      s1_ch      <= '0;
      s1_prod    <= '0;
      cal_valid  <= 1'b0;
      cal_out    <= '0;
      clip_flags <= '0;
      overrun    <= 1'b0;
      for (int c = 0; c < N; c++) begin
        lat[c]    <= '0;
        offset[c] <= '0;
        gain[c]   <= W'(1 << SHIFT);
      end
    end else begin
      cal_valid <= last_wr;
      s1_vld    <= issue;
      s1_ch     <= idx_ch;
      s1_prod   <= prod;
      if (accept) begin
        idx <= '0;
        for (int c = 0; c < N; c++) lat[c] <= uncal_in[c*W +: W];
      end else if (issue) begin
        idx <= idx + (CW+1)'(1);
      end
      if (s1_vld) cal_out[s1_ch*W +: W] <= lane_val;
      // A new set event outranks a simultaneous clear.
      clip_flags <= (clip_clr ? '0 : clip_flags) | clip_set;
      overrun    <= (overrun && !clip_clr) || (busy && sample_valid);
      if (coef_we && wr_ok) begin
        if (coef_addr[0]) gain[wr_ch]   <= coef_wdata;
        else              offset[wr_ch] <= coef_wdata;
      end
    end
  end
endmodule

// File: tb/tb_cal_engine.sv
// Testbench for cal_engine (W=16, N=4, SHIFT=8): a scoreboard queue of
// expected output sets, a behavioural calibration model, and directed timing,
// clamp, overrun and reset scenarios.
module tb_cal_engine;
  localparam int W = 16;
  localparam int N = 4;
  localparam int SHIFT = 8;
  localparam longint HI = 26000;
  localparam longint LO = -26000;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                sample_valid = 1'b0;
  logic [N*W-1:0]      uncal_in = '0;
  logic [N*W-1:0]      cal_out;
  logic                cal_valid, busy, overrun;
  logic                coef_we = 1'b0;
  logic [$clog2(N):0]  coef_addr = '0;
  logic [W-1:0]        coef_wdata = '0;
  logic [N-1:0]        clip_flags;
  logic                clip_clr = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int n_valid = 0;
  int nv;
  logic [N*W-1:0] exp_q[$];
  logic [N*W-1:0] exp_set;
  logic [N*W-1:0] tmp;
  longint off_m[N];
  longint gain_m[N];
  logic [N-1:0] clip_m;

  always #5 clk = ~clk;

  cal_engine #(.W(W), .N(N), .SHIFT(SHIFT), .CLAMP_HI(26000), .CLAMP_LO(-26000)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .uncal_in(uncal_in),
    .cal_out(cal_out), .cal_valid(cal_valid), .busy(busy),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .clip_flags(clip_flags), .clip_clr(clip_clr), .overrun(overrun)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input int c, input logic signed [W-1:0] x);
    longint d, p, r;
    d = longint'(x) - off_m[c];
    p = d * gain_m[c];
    r = p >>> SHIFT;
    if (r > HI) begin clip_m[c] = 1'b1; return W'(HI); end
    if (r < LO) begin clip_m[c] = 1'b1; return W'(LO); end
    return W'(r);
  endfunction

  function automatic logic [N*W-1:0] expect_set(input logic [N*W-1:0] in);
    logic [N*W-1:0] r;
    r = '0;
    for (int c = 0; c < N; c++) r[c*W +: W] = model(c, in[c*W +: W]);
    return r;
  endfunction

  function automatic logic [N*W-1:0] pack4(input int a, input int b, input int c, input int d);
    return {W'(d), W'(c), W'(b), W'(a)};
  endfunction

  task automatic reset_model();
    for (int c = 0; c < N; c++) begin off_m[c] = 0; gain_m[c] = 256; end
    clip_m = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_coef(input int ch, input bit is_gain, input int val);
    logic signed [W-1:0] v;
    v = W'(val);
    coef_we = 1'b1;
    coef_addr = ($clog2(N)+1)'(ch*2 + int'(is_gain));
    coef_wdata = v;
    tick();
    coef_we = 1'b0;
    if (is_gain) gain_m[ch] = longint'(v);
    else         off_m[ch]  = longint'(v);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 20) begin tick(); n++; end
    if (n >= 20) check("busy_timeout", 64'(busy), 64'(0));
    tick();
  endtask

  task automatic send(input logic [N*W-1:0] in, input logic [N*W-1:0] exp);
    logic [N*W-1:0] unused;
    unused = expect_set(in);
    uncal_in = in;
    exp_q.push_back(exp);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    wait_idle();
    check("clip_flags", 64'(clip_flags), 64'(clip_m));
  endtask

  always @(negedge clk) begin
    if (cal_valid === 1'b1) begin
      n_valid++;
      if (exp_q.size() == 0) check("spurious_valid", 64'(1), 64'(0));
      else begin
        tmp = exp_q.pop_front();
        for (int c = 0; c < N; c++)
          check($sformatf("lane%0d", c), 64'(cal_out[c*W +: W]), 64'(tmp[c*W +: W]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset_model();
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_cal_out", 64'(cal_out), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_valid", 64'(cal_valid), 64'(0));
    check("rst_clip", 64'(clip_flags), 64'(0));
    check("rst_overrun", 64'(overrun), 64'(0));

    // Unity path and cycle timing.
    exp_set = pack4(100, -200, 300, -400);
    uncal_in = exp_set;
    tmp = expect_set(exp_set);
    exp_q.push_back(exp_set);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    check("busy_k", 64'(busy), 64'(1));
    for (int j = 1; j <= 5; j++) begin
      tick();
      check($sformatf("busy_k%0d", j), 64'(busy), 64'(j <= 4));
      check($sformatf("valid_k%0d", j), 64'(cal_valid), 64'(j == 5));
      if (j == 2) begin
        check("lane0_at_k2", 64'(cal_out[15:0]), 64'(16'd100));
        check("lane1_at_k2", 64'(cal_out[31:16]), 64'(0));
      end
    end
    tick();

    // Offset and gain on channel 1.
    wr_coef(1, 0, 50);
    wr_coef(1, 1, 512);
    send(pack4(7, 150, -3, 9), pack4(7, 200, -3, 9));

    // Clamping.
    wr_coef(0, 1, 32767);
    send(pack4(10000, 50, 1, 2), pack4(26000, 0, 1, 2));
    check("clip_0001", 64'(clip_flags), 64'(4'b0001));
    send(pack4(-10000, 50, 1, 2), pack4(-26000, 0, 1, 2));
    clip_clr = 1'b1; tick(); clip_clr = 1'b0;
    clip_m = '0;
    check("clip_cleared", 64'(clip_flags), 64'(0));

    // Overrun: second strobe at k+2 is ignored, strobe at k+6 is accepted.
    nv = n_valid;
    exp_set = pack4(1, 2, 3, 4);
    uncal_in = exp_set;
    exp_q.push_back(expect_set(exp_set));
    sample_valid = 1'b1; tick(); sample_valid = 1'b0;
    tick();
    uncal_in = pack4(5000, 6000, 7000, 8000);
    sample_valid = 1'b1; tick(); sample_valid = 1'b0;
    check("overrun_set", 64'(overrun), 64'(1));
    repeat (3) tick();
    send(pack4(20, 60, 30, 40), expect_set(pack4(20, 60, 30, 40)));
    check("overrun_valid_count", 64'(n_valid - nv), 64'(2));
    check("overrun_sticky", 64'(overrun), 64'(1));
    clip_clr = 1'b1; tick(); clip_clr = 1'b0;
    clip_m = '0;
    check("overrun_cleared", 64'(overrun), 64'(0));

    // Writes racing the issue slot: ch3 write lands before its issue (new
    // value), ch2 write lands on its issue edge (old value).
    exp_set = pack4(1, 2, 300, 400);
    tmp = expect_set(exp_set);
    tmp[47:32] = 16'd300;
    tmp[63:48] = 16'd300;
    exp_q.push_back(tmp);
    uncal_in = exp_set;
    sample_valid = 1'b1; tick(); sample_valid = 1'b0;
    tick();
    coef_we = 1'b1; coef_addr = 3'd6; coef_wdata = 16'd100; tick();
    coef_addr = 3'd4; tick();
    coef_we = 1'b0;
    off_m[2] = 100; off_m[3] = 100;
    wait_idle();
    send(pack4(0, 50, 300, 100), pack4(0, 0, 200, 0));

    // Reset mid-set.
    uncal_in = pack4(1111, 2222, 3333, 4444);
    sample_valid = 1'b1; tick(); sample_valid = 1'b0;
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    reset_model();
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_cal_out", 64'(cal_out), 64'(0));
    check("abort_clip", 64'(clip_flags), 64'(0));
    for (int j = 0; j < 4; j++) begin
      tick();
      check("abort_no_valid", 64'(cal_valid), 64'(0));
    end
    send(pack4(1234, 1234, 1234, 1234), pack4(1234, 1234, 1234, 1234));

    // Randomised coefficient/sample sets against the model.
    for (int i = 0; i < 10; i++) begin
      int ch;
      ch = int'($urandom_range(0, N-1));
      wr_coef(ch, 1'b1, int'($urandom_range(0, 1023)));
      ch = int'($urandom_range(0, N-1));
      wr_coef(ch, 1'b0, int'($urandom_range(0, 4000)) - 2000);
      exp_set = {$urandom, $urandom};
      send(exp_set, expect_set(exp_set));
    end
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
